// File: rtl/joystick_conditioner_pkg.sv
// Shared definitions for the joystick conditioner.
//   JOY_BITS        number of lines per stick
//   JOY_UP..JOY_FIRE bit index of each line in the 5-bit vectors
//   rpt_state_t     per-line auto-repeat state
//   rpt_cnt_width   width of the repeat down-counter, never below 1
package joystick_pkg;

   localparam int JOY_BITS  = 5;
   localparam int JOY_UP    = 0;
   localparam int JOY_DOWN  = 1;
   localparam int JOY_LEFT  = 2;
   localparam int JOY_RIGHT = 3;
   localparam int JOY_FIRE  = 4;

   typedef enum logic [1:0] {
      RELEASED = 2'd0,
      DELAY    = 2'd1,
      REPEAT   = 2'd2
   } rpt_state_t;

   function automatic int rpt_cnt_width(input int unsigned delay, input int unsigned period);
      int unsigned m;
      m = (delay > period) ? delay : period;
      return (m <= 1) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/joystick_conditioner_if.sv
// Signal bundle between one joystick conditioner and its consumer.
//   joy_raw       raw pins, active-low, asynchronous
//   event_clr     write-1-to-clear for event_flags
//   stick_export  debounced level, active-high pressed
//   press_pulse   one-cycle press / repeat event
//   event_flags   sticky event flags
interface joystick_conditioner_if import joystick_pkg::*; ();

   logic [JOY_BITS-1:0] joy_raw;
   logic [JOY_BITS-1:0] event_clr;
   logic [JOY_BITS-1:0] stick_export;
   logic [JOY_BITS-1:0] press_pulse;
   logic [JOY_BITS-1:0] event_flags;

   modport master (
      output joy_raw, event_clr,
      input  stick_export, press_pulse, event_flags
   );

   modport slave (
      input  joy_raw, event_clr,
      output stick_export, press_pulse, event_flags
   );

endinterface

// File: rtl/joystick_bit_conditioner.sv
// One joystick line: 2-flop synchroniser, debounce and auto-repeat.
//   clk_i    system clock
//   rst_n_i  asynchronous active-low reset
//   raw_i    raw pin, active-low
//   level_o  debounced level, active-high pressed
//   pulse_o  one-cycle pulse on press and on each repeat
//
// state    | meaning
// RELEASED | line not pressed (debounced), counter idle
// DELAY    | pressed, counting down to the first repeat
// REPEAT   | pressed, counting down between repeats
module joystick_bit_conditioner import joystick_pkg::*; #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned REPEAT_DELAY    = 25000000,
   parameter int unsigned REPEAT_PERIOD   = 5000000,
   parameter bit          REPEAT_EN       = 1'b1
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic raw_i,
   output logic level_o,
   output logic pulse_o
);

   localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int RPT_W = rpt_cnt_width(REPEAT_DELAY, REPEAT_PERIOD);
   localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [RPT_W-1:0] DELAY_LOAD  = RPT_W'(REPEAT_DELAY - 1);
   localparam logic [RPT_W-1:0] PERIOD_LOAD = RPT_W'(REPEAT_PERIOD - 1);

   logic [1:0]       sync_q;
   logic [DB_W-1:0]  db_cnt_q;
   logic             level_q;
   rpt_state_t       state_q;
   logic [RPT_W-1:0] rpt_cnt_q;
   logic             pulse_q;

   logic sync;
   logic mismatch;
   logic db_done;
   logic rise;
   logic fall;

   // Chain carries the raw (active-low) value; it resets to the released level.
   assign sync     = ~sync_q[1];
   assign mismatch = (sync != level_q);
   assign db_done  = mismatch && (db_cnt_q == DB_LAST);
   assign rise     = db_done && !level_q;
   assign fall     = db_done && level_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sync_q    <= 2'b11;
         db_cnt_q  <= '0;
         level_q   <= 1'b0;
         state_q   <= RELEASED;
         rpt_cnt_q <= '0;
         pulse_q   <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], raw_i};

         if (!mismatch) begin
            db_cnt_q <= '0;
         end else if (db_done) begin
            db_cnt_q <= '0;
            level_q  <= ~level_q;
         end else begin
            db_cnt_q <= db_cnt_q + 1'b1;
         end

         pulse_q <= 1'b0;
         if (fall) begin
            state_q   <= RELEASED;
            rpt_cnt_q <= '0;
         end else begin
            case (state_q)
               RELEASED: begin
                  if (rise) begin
                     state_q   <= DELAY;
                     pulse_q   <= 1'b1;
                     rpt_cnt_q <= DELAY_LOAD;
                  end
               end
               DELAY: begin
                  // With repeat disabled the line parks here, counter frozen.
                  if (REPEAT_EN) begin
                     if (rpt_cnt_q == '0) begin
                        state_q   <= REPEAT;
                        pulse_q   <= 1'b1;
                        rpt_cnt_q <= PERIOD_LOAD;
                     end else begin
                        rpt_cnt_q <= rpt_cnt_q - 1'b1;
                     end
                  end
               end
               REPEAT: begin
                  if (rpt_cnt_q == '0) begin
                     pulse_q   <= 1'b1;
                     rpt_cnt_q <= PERIOD_LOAD;
                  end else begin
                     rpt_cnt_q <= rpt_cnt_q - 1'b1;
                  end
               end
               default: begin
                  state_q   <= RELEASED;
                  rpt_cnt_q <= '0;
               end
            endcase
         end
      end
   end

   assign level_o = level_q;
   assign pulse_o = pulse_q;

endmodule

// File: rtl/joystick_conditioner.sv
// Conditions one 5-line digital joystick for the PIO input.
//   clk_clk        system clock
//   reset_reset_n  asynchronous active-low reset
//   jif            slave side: joy_raw/event_clr in,
//                  stick_export/press_pulse/event_flags out
module joystick_conditioner import joystick_pkg::*; #(
   parameter int unsigned         DEBOUNCE_CYCLES = 500000,
   parameter int unsigned         REPEAT_DELAY    = 25000000,
   parameter int unsigned         REPEAT_PERIOD   = 5000000,
   parameter logic [JOY_BITS-1:0] REPEAT_MASK     = 5'b01111
) (
   input  logic                   clk_clk,
   input  logic                   reset_reset_n,
   joystick_conditioner_if.slave  jif
);

   logic [JOY_BITS-1:0] level_w;
   logic [JOY_BITS-1:0] pulse_w;
   logic [JOY_BITS-1:0] flags_q;
   logic [JOY_BITS-1:0] flags_d;

   for (genvar i = 0; i < JOY_BITS; i++) begin : g_bit
      joystick_bit_conditioner #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD),
         .REPEAT_EN       (REPEAT_MASK[i])
      ) u_bit (
         .clk_i   (clk_clk),
         .rst_n_i (reset_reset_n),
         .raw_i   (jif.joy_raw[i]),
         .level_o (level_w[i]),
         .pulse_o (pulse_w[i])
      );
   end

   // A new event beats a clear arriving in the same cycle.
   assign flags_d = pulse_w | (flags_q & ~jif.event_clr);

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         flags_q <= '0;
      end else begin
         flags_q <= flags_d;
      end
   end

   assign jif.stick_export = level_w;
   assign jif.press_pulse  = pulse_w;
   assign jif.event_flags  = flags_q;

endmodule

// File: tb/tb_joystick_conditioner.sv
// Testbench for joystick_conditioner with short debounce/repeat timing.
module tb_joystick_conditioner;
   import joystick_pkg::*;

   localparam int D = 4;
   localparam int R = 10;
   localparam int P = 3;
   localparam logic [4:0] MASK = 5'b01111;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int errors = 0;

   joystick_conditioner_if jif();

   joystick_conditioner #(
      .DEBOUNCE_CYCLES (D),
      .REPEAT_DELAY    (R),
      .REPEAT_PERIOD   (P),
      .REPEAT_MASK     (MASK)
   ) dut (
      .clk_clk       (clk),
      .reset_reset_n (rst_n),
      .jif           (jif.slave)
   );

   always #5 clk = ~clk;

   // Reference model: raw delay line, run-length debounce, press age for repeats.
   logic [4:0] m_s1, m_s2, m_lvl, m_pulse, m_flags;
   int m_run[5];
   int m_age[5];

   task automatic model_reset();
      m_s1 = '1; m_s2 = '1; m_lvl = '0; m_pulse = '0; m_flags = '0;
      for (int i = 0; i < 5; i++) begin
         m_run[i] = 0;
         m_age[i] = -1;
      end
   endtask

   task automatic model_edge();
      logic [4:0] nl, np, nf;
      logic sync, rise, fall;
      nf = m_pulse | (m_flags & ~jif.event_clr);
      nl = m_lvl;
      np = '0;
      for (int i = 0; i < 5; i++) begin
         sync = ~m_s2[i];
         rise = 1'b0;
         fall = 1'b0;
         if (sync != m_lvl[i]) begin
            m_run[i]++;
            if (m_run[i] == D) begin
               nl[i] = sync;
               m_run[i] = 0;
               rise = sync;
               fall = !sync;
            end
         end else begin
            m_run[i] = 0;
         end
         if (rise) begin
            m_age[i] = 0;
            np[i] = 1'b1;
         end else if (fall) begin
            m_age[i] = -1;
         end else if (m_age[i] >= 0) begin
            m_age[i]++;
            if (MASK[i] && m_age[i] >= R && ((m_age[i] - R) % P) == 0) np[i] = 1'b1;
         end
      end
      m_s2 = m_s1;
      m_s1 = jif.joy_raw;
      m_lvl = nl;
      m_pulse = np;
      m_flags = nf;
   endtask

   task automatic step();
      @(posedge clk);
      if (rst_n) model_edge();
      else model_reset();
      #1;
   endtask

   task automatic test_reset();
      jif.joy_raw = 5'b11111;
      jif.event_clr = '0;
      rst_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if (jif.stick_export !== 5'b0 || jif.press_pulse !== 5'b0 || jif.event_flags !== 5'b0) begin
         errors++;
         $display("FAIL reset_values act=%b/%b/%b exp=00000/00000/00000",
                  jif.stick_export, jif.press_pulse, jif.event_flags);
      end
      step(); step();
      rst_n = 1'b1;
      for (int k = 1; k <= 100; k++) begin
         step();
         checks++;
         if (jif.stick_export !== 5'b0 || jif.press_pulse !== 5'b0) begin
            errors++;
            $display("FAIL idle k=%0d act=%b/%b exp=00000/00000", k, jif.stick_export, jif.press_pulse);
         end
      end
   endtask

   task automatic test_glitch();
      jif.joy_raw = 5'b11110;
      for (int k = 1; k <= 23; k++) begin
         step();
         if (k == 3) jif.joy_raw = 5'b11111;
         checks++;
         if (jif.stick_export !== 5'b0 || jif.press_pulse !== 5'b0 || jif.event_flags !== 5'b0) begin
            errors++;
            $display("FAIL glitch k=%0d act=%b/%b/%b exp=00000/00000/00000",
                     k, jif.stick_export, jif.press_pulse, jif.event_flags);
         end
      end
   endtask

   task automatic test_hold_repeat();
      logic [4:0] exp_lvl, exp_pulse;
      jif.joy_raw = 5'b11011;
      for (int k = 1; k <= 31; k++) begin
         step();
         if (k == 23) jif.joy_raw = 5'b11111;
         exp_lvl = (k >= 6 && k < 29) ? 5'b00100 : 5'b00000;
         exp_pulse = (k == 6 || (k >= 16 && k < 29 && ((k - 16) % 3) == 0)) ? 5'b00100 : 5'b00000;
         checks++;
         if (jif.stick_export !== exp_lvl || jif.press_pulse !== exp_pulse) begin
            errors++;
            $display("FAIL hold_repeat k=%0d act=%b/%b exp=%b/%b",
                     k, jif.stick_export, jif.press_pulse, exp_lvl, exp_pulse);
         end
      end
   endtask

   task automatic test_fire_sticky();
      int npulse = 0;
      jif.event_clr = 5'b11111;
      step();
      jif.event_clr = '0;
      jif.joy_raw = 5'b01111;
      for (int k = 1; k <= 50; k++) begin
         step();
         if (jif.press_pulse[JOY_FIRE]) npulse++;
         checks++;
         if (jif.event_flags[JOY_FIRE] !== (k >= 7)) begin
            errors++;
            $display("FAIL fire_flag k=%0d act=%b exp=%b", k, jif.event_flags[JOY_FIRE], k >= 7);
         end
      end
      checks++;
      if (npulse != 1) begin
         errors++;
         $display("FAIL fire_pulse_count act=%0d exp=1", npulse);
      end
      jif.joy_raw = 5'b11111;
      for (int k = 1; k <= 10; k++) step();
      checks++;
      if (jif.stick_export[JOY_FIRE] !== 1'b0 || jif.event_flags[JOY_FIRE] !== 1'b1) begin
         errors++;
         $display("FAIL fire_release act=%b/%b exp=0/1", jif.stick_export[JOY_FIRE], jif.event_flags[JOY_FIRE]);
      end
      jif.event_clr = 5'b10000;
      step();
      jif.event_clr = '0;
      checks++;
      if (jif.event_flags[JOY_FIRE] !== 1'b0) begin
         errors++;
         $display("FAIL fire_clear act=%b exp=0", jif.event_flags[JOY_FIRE]);
      end
   endtask

   task automatic test_clr_collision();
      jif.joy_raw = 5'b11101;
      for (int k = 1; k <= 6; k++) step();
      checks++;
      if (jif.press_pulse[JOY_DOWN] !== 1'b1 || jif.event_flags[JOY_DOWN] !== 1'b0) begin
         errors++;
         $display("FAIL collide_pre act=%b/%b exp=1/0", jif.press_pulse[JOY_DOWN], jif.event_flags[JOY_DOWN]);
      end
      jif.event_clr = 5'b00010;
      step();
      jif.event_clr = '0;
      checks++;
      if (jif.event_flags[JOY_DOWN] !== 1'b1) begin
         errors++;
         $display("FAIL collide_set_wins act=%b exp=1", jif.event_flags[JOY_DOWN]);
      end
      jif.joy_raw = 5'b11111;
      for (int k = 1; k <= 10; k++) step();
   endtask

   task automatic test_reset_midhold();
      logic [4:0] exp_lvl, exp_pulse;
      jif.joy_raw = 5'b10110;
      for (int k = 1; k <= 20; k++) step();
      rst_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if (jif.stick_export !== 5'b0 || jif.press_pulse !== 5'b0 || jif.event_flags !== 5'b0) begin
         errors++;
         $display("FAIL midhold_reset act=%b/%b/%b exp=00000/00000/00000",
                  jif.stick_export, jif.press_pulse, jif.event_flags);
      end
      step(); step();
      rst_n = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         step();
         exp_lvl = (k >= 6) ? 5'b01001 : 5'b00000;
         exp_pulse = (k == 6) ? 5'b01001 : 5'b00000;
         checks++;
         if (jif.stick_export !== exp_lvl || jif.press_pulse !== exp_pulse) begin
            errors++;
            $display("FAIL midhold_repress k=%0d act=%b/%b exp=%b/%b",
                     k, jif.stick_export, jif.press_pulse, exp_lvl, exp_pulse);
         end
      end
      jif.joy_raw = 5'b11111;
      for (int k = 1; k <= 10; k++) step();
   endtask

   task automatic test_random();
      int div;
      for (int k = 0; k < 3000; k++) begin
         div = (k < 1500) ? 10 : 30;
         for (int i = 0; i < 5; i++)
            if ($urandom_range(0, div - 1) == 0) jif.joy_raw[i] = ~jif.joy_raw[i];
         jif.event_clr = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'b0;
         step();
         checks++;
         if (jif.stick_export !== m_lvl || jif.press_pulse !== m_pulse || jif.event_flags !== m_flags) begin
            errors++;
            $display("FAIL random k=%0d act=%b/%b/%b exp=%b/%b/%b", k,
                     jif.stick_export, jif.press_pulse, jif.event_flags, m_lvl, m_pulse, m_flags);
         end
      end
      jif.event_clr = '0;
   endtask

   initial begin
      test_reset();
      test_glitch();
      test_hold_repeat();
      test_fire_sticky();
      test_clr_collision();
      test_reset_midhold();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
